// File: rtl/hp1349a_pkg.sv
// Shared constants and types for the HP1349A VGA scanout stage.
package hp1349a_pkg;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;

    localparam int WORDS_PER_LINE = 40;
    localparam int LINE_STRIDE    = 64;

    // Fetch strobe fires one pixel early so HOLD occupies hcnt 638..639.
    localparam int FETCH_START = H_VIS - 3;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        ADDR,
        LATCH,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/hp1349a_vga_timing.sv
// 640x480 raster counters, registered sync/de, fetch-line strobe and, when
// HP1349A_SCANOUT_GRATICULE_EN is defined, the registered graticule pixel.
module hp1349a_vga_timing
    import hp1349a_pkg::*;
#(
    parameter int VIS_LINES   = V_VIS,
    parameter int VFP_LINES   = V_FP,
    parameter int VSYNC_LINES = V_SYNC,
    parameter int VBP_LINES   = V_BP
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hcnt,
    output logic       active,
    output logic       fetch_go,
    output logic [9:0] fetch_line,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       grat
);

    localparam int          V_TOTAL   = VIS_LINES + VFP_LINES + VSYNC_LINES + VBP_LINES;
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS_W    = 10'(H_VIS);
    localparam logic [9:0] HS_BEGIN   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] H_FETCH    = 10'(FETCH_START);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS_W    = 10'(VIS_LINES);
    localparam logic [9:0] V_VIS_LAST = 10'(VIS_LINES - 1);
    localparam logic [9:0] VS_BEGIN   = 10'(VIS_LINES + VFP_LINES);
    localparam logic [9:0] VS_END     = 10'(VIS_LINES + VFP_LINES + VSYNC_LINES);

    logic [9:0] vcnt;

    assign active     = (hcnt < H_VIS_W) && (vcnt < V_VIS_W);
    assign fetch_go   = (hcnt == H_FETCH) && ((vcnt < V_VIS_LAST) || (vcnt == V_LAST));
    assign fetch_line = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge counter values, keeping all vga outputs aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt  <= '0;
            vcnt  <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            de    <= 1'b0;
        end else begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
            hsync <= !((hcnt >= HS_BEGIN) && (hcnt < HS_END));
            vsync <= !((vcnt >= VS_BEGIN) && (vcnt < VS_END));
            de    <= active;
        end
    end

`ifdef HP1349A_SCANOUT_GRATICULE_EN
    logic grat_hit;
    assign grat_hit = active && ((hcnt[5:0] == 6'd0) || (hcnt == H_VIS_W - 10'd1) ||
                                 ((vcnt % 10'd60) == 10'd0) || (vcnt == V_VIS_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) grat <= 1'b0;
        else     grat <= grat_hit;
    end
`else
    assign grat = 1'b0;
`endif

endmodule

// File: rtl/hp1349a_vga_scanout.sv
// VGA scanout: fetches each upcoming 1 bpp line from SRAM during hblank and
// shifts it out. Optional graticule overlay: HP1349A_SCANOUT_GRATICULE_EN.
module hp1349a_vga_scanout
    import hp1349a_pkg::*;
#(
    parameter int VIS_LINES   = V_VIS,
    parameter int VFP_LINES   = V_FP,
    parameter int VSYNC_LINES = V_SYNC,
    parameter int VBP_LINES   = V_BP
) (
    input  logic        clk,
    input  logic        rst,
    output logic [19:0] FB_ADDR,
    input  logic [15:0] FB_DQ_IN,
    output logic        FB_CE_N,
    output logic        FB_OE_N,
    output logic        FB_WE_N,
    output logic        FB_UB_N,
    output logic        FB_LB_N,
    output logic        fb_sel,
    output logic        draw_en,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_de,
    output logic        vga_pix,
    output logic        vga_grat
);

    localparam logic [5:0] LAST_WORD = 6'(WORDS_PER_LINE - 1);

    logic [9:0]   hcnt;
    logic         active;
    logic         fetch_go;
    logic [9:0]   fetch_line;
    fetch_state_t state;
    logic         hold_cnt;
    logic [5:0]   word;
    logic [19:0]  line_base;
    logic [15:0]  linebuf [0:WORDS_PER_LINE-1];

    hp1349a_vga_timing #(
        .VIS_LINES   (VIS_LINES),
        .VFP_LINES   (VFP_LINES),
        .VSYNC_LINES (VSYNC_LINES),
        .VBP_LINES   (VBP_LINES)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .hcnt       (hcnt),
        .active     (active),
        .fetch_go   (fetch_go),
        .fetch_line (fetch_line),
        .hsync      (vga_hsync),
        .vsync      (vga_vsync),
        .de         (vga_de),
        .grat       (vga_grat)
    );

    assign FB_WE_N = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= 1'b0;
            word      <= '0;
            line_base <= '0;
            FB_ADDR   <= '0;
            FB_CE_N   <= 1'b1;
            FB_OE_N   <= 1'b1;
            FB_UB_N   <= 1'b1;
            FB_LB_N   <= 1'b1;
            fb_sel    <= 1'b0;
            draw_en   <= 1'b1;
        end else begin
            case (state)
                IDLE: if (fetch_go) begin
                    state     <= HOLD;
                    draw_en   <= 1'b0;
                    hold_cnt  <= 1'b0;
                    line_base <= 20'(fetch_line) * 20'(LINE_STRIDE);
                end
                // Two idle cycles let the draw stage retire its in-flight access.
                HOLD: if (hold_cnt) begin
                    state   <= ADDR;
                    fb_sel  <= 1'b1;
                    FB_CE_N <= 1'b0;
                    FB_OE_N <= 1'b0;
                    FB_UB_N <= 1'b0;
                    FB_LB_N <= 1'b0;
                    FB_ADDR <= line_base;
                    word    <= '0;
                end else begin
                    hold_cnt <= 1'b1;
                end
                ADDR: state <= LATCH;
                LATCH: if (word == LAST_WORD) begin
                    state   <= DONE;
                    fb_sel  <= 1'b0;
                    FB_CE_N <= 1'b1;
                    FB_OE_N <= 1'b1;
                    FB_UB_N <= 1'b1;
                    FB_LB_N <= 1'b1;
                end else begin
                    state   <= ADDR;
                    word    <= word + 6'd1;
                    FB_ADDR <= FB_ADDR + 20'd1;
                end
                DONE: begin
                    state   <= IDLE;
                    draw_en <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the line buffer is a plain RAM with no reset; stale contents are
    // only ever visible on line 0 of the first frame.
    always_ff @(posedge clk) begin
        if (state == LATCH) linebuf[word] <= FB_DQ_IN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vga_pix <= 1'b0;
        else     vga_pix <= active && linebuf[hcnt[9:4]][hcnt[3:0]];
    end

endmodule

// File: tb/tb_hp1349a_vga_scanout.sv
// Directed self-checking bench for hp1349a_vga_scanout (vertical timing shrunk
// to 11 lines per frame so several frames fit in a short run).
module tb_hp1349a_vga_scanout;

    localparam int VIS = 6;
    localparam int VFP = 1;
    localparam int VSY = 2;
    localparam int VBP = 2;
    localparam int VT  = VIS + VFP + VSY + VBP;
    localparam int FRAME = 800 * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] FB_ADDR;
    logic [15:0] FB_DQ_IN;
    logic        FB_CE_N, FB_OE_N, FB_WE_N, FB_UB_N, FB_LB_N;
    logic        fb_sel, draw_en;
    logic        vga_hsync, vga_vsync, vga_de, vga_pix, vga_grat;

    int errors = 0;
    int checks = 0;
    int n = 0;
    int phase = 0;
    int hs_bad = 0, vs_bad = 0, de_bad = 0, pix_bad = 0, grat_bad = 0, bus_bad = 0;
    int hs_low = 0, vs_low = 0, de_cnt = 0, pix_cnt = 0;

    hp1349a_vga_scanout #(
        .VIS_LINES   (VIS),
        .VFP_LINES   (VFP),
        .VSYNC_LINES (VSY),
        .VBP_LINES   (VBP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .FB_ADDR   (FB_ADDR),
        .FB_DQ_IN  (FB_DQ_IN),
        .FB_CE_N   (FB_CE_N),
        .FB_OE_N   (FB_OE_N),
        .FB_WE_N   (FB_WE_N),
        .FB_UB_N   (FB_UB_N),
        .FB_LB_N   (FB_LB_N),
        .fb_sel    (fb_sel),
        .draw_en   (draw_en),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync),
        .vga_de    (vga_de),
        .vga_pix   (vga_pix),
        .vga_grat  (vga_grat)
    );

    always #20 clk = ~clk;

    // Asynchronous SRAM: three lit words, everything else blank.
    function automatic logic [15:0] sram_word(input logic [19:0] a);
        case (a)
            20'd0:   return 16'h0001;
            20'd64:  return 16'h8000;
            20'd167: return 16'h4000;
            default: return 16'h0000;
        endcase
    endfunction

    assign FB_DQ_IN = (!FB_CE_N && !FB_OE_N) ? sram_word(FB_ADDR) : 16'h0000;

    function automatic bit exp_pix(input int x, input int y);
        return (x == 0 && y == 0) || (x == 15 && y == 1) || (x == 638 && y == 2);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle and compare every output against the raster model.
    task automatic step();
        int h, v, f, hp, vp, fp, nl;
        bit act, fl, e_sel, e_draw, e_grat;
        @(negedge clk);
        n++;
        h  = n % 800;           v  = (n / 800) % VT;       f  = n / FRAME;
        hp = (n - 1) % 800;     vp = ((n - 1) / 800) % VT; fp = (n - 1) / FRAME;
        act = (hp < 640) && (vp < VIS);

        if (vga_hsync !== !(hp >= 656 && hp < 752)) hs_bad++;
        if (vga_vsync !== !(vp >= VIS + VFP && vp < VIS + VFP + VSY)) vs_bad++;
        if (vga_de !== act) de_bad++;
`ifdef HP1349A_SCANOUT_GRATICULE_EN
        e_grat = act && ((hp % 64) == 0 || hp == 639 || (vp % 60) == 0 || vp == VIS - 1);
`else
        e_grat = 1'b0;
`endif
        if (vga_grat !== e_grat) grat_bad++;
        if (!(fp == 0 && vp == 0)) begin
            if (vga_pix !== (act && exp_pix(hp, vp))) pix_bad++;
            if (vga_pix) pix_cnt++;
        end
        if (!vga_hsync) hs_low++;
        if (!vga_vsync) vs_low++;
        if (vga_de) de_cnt++;

        fl     = (v < VIS - 1) || (v == VT - 1);
        nl     = (v == VT - 1) ? 0 : v + 1;
        e_draw = !(fl && h >= 638 && h <= 720);
        e_sel  = fl && h >= 640 && h <= 719;
        if (draw_en !== e_draw) bus_bad++;
        if (fb_sel !== e_sel) bus_bad++;
        if (FB_CE_N !== !e_sel || FB_OE_N !== !e_sel) bus_bad++;
        if (FB_UB_N !== !e_sel || FB_LB_N !== !e_sel) bus_bad++;
        if (FB_WE_N !== 1'b1) bus_bad++;
        if (e_sel && FB_ADDR !== 20'(nl * 64 + (h - 640) / 2)) bus_bad++;

        if (phase == 0 && f == 0 && v == VT - 1) begin
            case (h)
                637: check("draw_en_before_fetch", draw_en, 1);
                638: check("draw_en_falls", draw_en, 0);
                639: check("fb_sel_during_hold", fb_sel, 0);
                640: begin
                    check("fb_sel_rises", fb_sel, 1);
                    check("ce_n_with_fb_sel", FB_CE_N, 0);
                    check("addr_word0_line0", FB_ADDR, 0);
                end
                642: check("addr_word1_line0", FB_ADDR, 1);
                719: check("addr_word39_line0", FB_ADDR, 39);
                720: begin
                    check("fb_sel_done", fb_sel, 0);
                    check("draw_en_done", draw_en, 0);
                end
                721: check("draw_en_returns", draw_en, 1);
                default: ;
            endcase
        end
        if (phase == 1 && f == 0 && v == 0) begin
            case (h)
                640: begin
                    check("post_reset_fb_sel", fb_sel, 1);
                    check("post_reset_addr_word0", FB_ADDR, 64);
                end
                642: check("post_reset_addr_word1", FB_ADDR, 65);
                default: ;
            endcase
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_hsync"}, vga_hsync, 1);
        check({pfx, "_vsync"}, vga_vsync, 1);
        check({pfx, "_de"}, vga_de, 0);
        check({pfx, "_pix"}, vga_pix, 0);
        check({pfx, "_grat"}, vga_grat, 0);
        check({pfx, "_ce_n"}, FB_CE_N, 1);
        check({pfx, "_oe_n"}, FB_OE_N, 1);
        check({pfx, "_we_n"}, FB_WE_N, 1);
        check({pfx, "_ub_n"}, FB_UB_N, 1);
        check({pfx, "_lb_n"}, FB_LB_N, 1);
        check({pfx, "_addr"}, FB_ADDR, 0);
        check({pfx, "_fb_sel"}, fb_sel, 0);
        check({pfx, "_draw_en"}, draw_en, 1);
    endtask

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        n = 0;

        for (int i = 0; i < 3 * FRAME; i++) step();
        check("hsync_low_cycles", hs_low, 3 * VT * 96);
        check("vsync_low_cycles", vs_low, 3 * VSY * 800);
        check("de_high_cycles", de_cnt, 3 * VIS * 640);
        check("pix_lit_count", pix_cnt, 8);

        // Walk into the line-1 fetch and cut it at word 20.
        found = 1'b0;
        for (int i = 0; i < 2 * 800 && !found; i++) begin
            step();
            if ((n % 800) == 680 && ((n / 800) % VT) == 0) found = 1'b1;
        end
        check("reached_word20", found, 1);
        check("mid_fetch_addr", FB_ADDR, 84);
        check("mid_fetch_fb_sel", fb_sel, 1);
        rst = 1'b1;
        #1;
        check_reset_values("abort");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        phase = 1;
        for (int i = 0; i < 1000; i++) step();

        check("hsync_shape", hs_bad, 0);
        check("vsync_shape", vs_bad, 0);
        check("de_shape", de_bad, 0);
        check("pix_shape", pix_bad, 0);
        check("grat_shape", grat_bad, 0);
        check("sram_bus_shape", bus_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
